// File: rtl/rc_stim_gen_if.sv
// rc_stim_gen_if: configuration, control and stimulus signals of the RC pulse-train generator
interface rc_stim_gen_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16,
    parameter int NP_W  = 8
);
    logic                    start;
    logic                    abort;
    logic signed [WIDTH-1:0] level_hi;
    logic signed [WIDTH-1:0] level_lo;
    logic        [CNT_W-1:0] t_hi;
    logic        [CNT_W-1:0] t_lo;
    logic        [NP_W-1:0]  n_pulses;
    logic signed [WIDTH-1:0] v_in;
    logic                    busy;
    logic                    phase;
    logic        [NP_W-1:0]  pulse_idx;
    logic                    done;

    modport master (
        output start, abort, level_hi, level_lo, t_hi, t_lo, n_pulses,
        input  v_in, busy, phase, pulse_idx, done
    );

    modport slave (
        input  start, abort, level_hi, level_lo, t_hi, t_lo, n_pulses,
        output v_in, busy, phase, pulse_idx, done
    );
endinterface

// File: rtl/rc_stim_gen.sv
// rc_stim_gen: plays back N high/low pulses of programmed levels and cycle-exact durations, then pulses done
module rc_stim_gen #(
    parameter int WIDTH    = 16,
    parameter int EXPONENT = -12,
    parameter int CNT_W    = 16,
    parameter int NP_W     = 8
) (
    input logic        clk,
    input logic        rst,
    rc_stim_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    // EXPONENT only describes the consumer's real-signal format; reject nonsensical values early
    if (EXPONENT > 0 || EXPONENT < -(8 * WIDTH)) begin : g_bad_exponent
        $error("rc_stim_gen: EXPONENT out of range");
    end

    state_t                  state_q;
    logic signed [WIDTH-1:0] v_in_q;
    logic signed [WIDTH-1:0] hi_q;
    logic signed [WIDTH-1:0] lo_q;
    logic        [CNT_W-1:0] th_q;
    logic        [CNT_W-1:0] tl_q;
    logic        [CNT_W-1:0] cnt_q;
    logic        [NP_W-1:0]  n_q;
    logic        [NP_W-1:0]  idx_q;
    logic                    busy_q;
    logic                    phase_q;
    logic                    done_q;
    logic        [CNT_W-1:0] th_d;
    logic        [CNT_W-1:0] tl_d;

    assign th_d = (bus.t_hi == '0) ? CNT_W'(1) : bus.t_hi;
    assign tl_d = (bus.t_lo == '0) ? CNT_W'(1) : bus.t_lo;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            v_in_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            th_q    <= '0;
            tl_q    <= '0;
            cnt_q   <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            phase_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        hi_q <= bus.level_hi;
                        lo_q <= bus.level_lo;
                        th_q <= th_d;
                        tl_q <= tl_d;
                        n_q  <= bus.n_pulses;
                        if (bus.n_pulses == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= HIGH;
                            v_in_q  <= bus.level_hi;
                            phase_q <= 1'b1;
                            busy_q  <= 1'b1;
                            idx_q   <= '0;
                            cnt_q   <= th_d - 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        v_in_q  <= lo_q;
                        busy_q  <= 1'b0;
                        phase_q <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        state_q <= LOW;
                        v_in_q  <= lo_q;
                        phase_q <= 1'b0;
                        cnt_q   <= tl_q - 1'b1;
                    end
                end
                LOW: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        v_in_q  <= lo_q;
                        busy_q  <= 1'b0;
                        phase_q <= 1'b0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (idx_q == n_q - 1'b1) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= HIGH;
                        idx_q   <= idx_q + 1'b1;
                        v_in_q  <= hi_q;
                        phase_q <= 1'b1;
                        cnt_q   <= th_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.v_in      = v_in_q;
    assign bus.busy      = busy_q;
    assign bus.phase     = phase_q;
    assign bus.pulse_idx = idx_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_rc_stim_gen.sv
// tb_rc_stim_gen: directed checks of reset, pulse timing, signed trains, zero pulses, abort and mid-run reset
module tb_rc_stim_gen;
    localparam int WIDTH = 16;
    localparam int CNT_W = 16;
    localparam int NP_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    rc_stim_gen_if #(.WIDTH(WIDTH), .CNT_W(CNT_W), .NP_W(NP_W)) bus ();

    rc_stim_gen #(.WIDTH(WIDTH), .EXPONENT(-12), .CNT_W(CNT_W), .NP_W(NP_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic chk_all(input string tag, input int v, input int b, input int p, input int idx, input int d);
        chk({tag, ".v_in"}, bus.v_in, v);
        chk({tag, ".busy"}, 32'(bus.busy), b);
        chk({tag, ".phase"}, 32'(bus.phase), p);
        chk({tag, ".pulse_idx"}, 32'(bus.pulse_idx), idx);
        chk({tag, ".done"}, 32'(bus.done), d);
    endtask

    task automatic cfg(input int hi, input int lo, input int th, input int tl, input int n);
        bus.level_hi = WIDTH'(hi);
        bus.level_lo = WIDTH'(lo);
        bus.t_hi     = CNT_W'(th);
        bus.t_lo     = CNT_W'(tl);
        bus.n_pulses = NP_W'(n);
    endtask

    initial begin
        int exp_v [6];
        int exp_i [6];
        bus.start = 1'b1;
        bus.abort = 1'b0;
        cfg(int'($urandom), int'($urandom), int'($urandom), int'($urandom), int'($urandom_range(1, 200)));
        tick();
        tick();
        chk_all("reset", 0, 0, 0, 0, 0);
        bus.start = 1'b0;
        rst = 1'b1;
        tick();
        chk_all("post_reset_idle", 0, 0, 0, 0, 0);

        cfg(4096, 0, 3, 2, 1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            chk_all($sformatf("single_c%0d", c), c <= 3 ? 4096 : 0, 1, c <= 3 ? 1 : 0, 0, 0);
            tick();
        end
        chk_all("single_done", 0, 0, 0, 0, 1);
        tick();
        chk_all("single_after", 0, 0, 0, 0, 0);

        cfg(-2048, 1024, 0, 1, 3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk_all($sformatf("train_c%0d", c), (c % 2 == 0) ? -2048 : 1024, 1, (c % 2 == 0) ? 1 : 0, c / 2, 0);
            tick();
        end
        chk_all("train_done", 1024, 0, 0, 2, 1);
        tick();
        chk_all("train_after", 1024, 0, 0, 2, 0);

        cfg(77, 88, 4, 4, 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk_all("zero_done", 1024, 0, 0, 2, 1);
        tick();
        chk_all("zero_after", 1024, 0, 0, 2, 0);

        cfg(300, -7, 5, 1, 2);
        bus.start = 1'b1;
        tick();
        chk_all("abort_c1", 300, 1, 1, 0, 0);
        cfg(999, 555, 1, 1, 9);
        tick();
        bus.start = 1'b0;
        chk_all("abort_c2_restart_ignored", 300, 1, 1, 0, 0);
        tick();
        chk_all("abort_c3", 300, 1, 1, 0, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk_all("abort_idle", -7, 0, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_all($sformatf("abort_no_done%0d", c), -7, 0, 0, 0, 0);
        end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk_all("start_abort_same", -7, 0, 0, 0, 0);
        tick();
        chk_all("start_abort_after", -7, 0, 0, 0, 0);

        cfg(100, 200, 2, 3, 2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 7; c++) tick();
        chk_all("midrun_low_p1", 200, 1, 0, 1, 0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_all("midrun_reset", 0, 0, 0, 0, 0);

        cfg(50, -50, 1, 2, 2);
        exp_v = '{50, -50, -50, 50, -50, -50};
        exp_i = '{0, 0, 0, 1, 1, 1};
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk_all($sformatf("rerun_c%0d", c), exp_v[c], 1, (exp_v[c] > 0) ? 1 : 0, exp_i[c], 0);
            tick();
        end
        chk_all("rerun_done", -50, 0, 0, 1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
